// File: rtl/cmd_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_serializer
//  Purpose  : Latches one reader command, shifts it out MSB first on bit_req
//             strobes and appends CRC5 (Query) or inverted CRC16 (ReqRN).
//  Revision : 1.0 - initial release
// ============================================================================
module cmd_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  cmd_sel,
    input  logic        dr,
    input  logic        trext,
    input  logic        target,
    input  logic [1:0]  m,
    input  logic [1:0]  sel,
    input  logic [1:0]  session,
    input  logic [3:0]  q,
    input  logic [2:0]  updn,
    input  logic [15:0] rn16,
    input  logic        bit_req,
    output logic        bitout,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CRC  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [4:0]  c_CRC5_PRESET  = 5'b01001;
    localparam logic [4:0]  c_CRC5_POLY    = 5'b01001;
    localparam logic [15:0] c_CRC16_PRESET = 16'hFFFF;
    localparam logic [15:0] c_CRC16_POLY   = 16'h1021;

    state_t      r_state;
    logic [23:0] r_shift;
    logic [5:0]  r_cnt;
    logic        r_has_crc;
    logic        r_crc16_sel;
    logic [4:0]  r_crc5;
    logic [15:0] r_crc16;

    state_t      w_state;
    logic [23:0] w_shift;
    logic [5:0]  w_cnt;
    logic        w_has_crc;
    logic        w_crc16_sel;
    logic [4:0]  w_crc5;
    logic [15:0] w_crc16;
    logic        w_bit;
    logic [23:0] w_frame;
    logic [5:0]  w_len;
    logic        w_crc5_fb;
    logic        w_crc16_fb;

    // Frames are left-aligned so the shift register MSB is always the next bit.
    always_comb begin
        w_frame = 24'd0;
        w_len   = 6'd0;
        case (cmd_sel)
            3'd0: begin w_frame = {2'b00, session, 20'd0};                                   w_len = 6'd4;  end
            3'd1: begin w_frame = {2'b01, rn16, 6'd0};                                       w_len = 6'd18; end
            3'd2: begin w_frame = {4'b1000, dr, m, trext, sel, session, target, q, 7'd0};   w_len = 6'd17; end
            3'd3: begin w_frame = {4'b1001, session, updn, 15'd0};                           w_len = 6'd9;  end
            3'd4: begin w_frame = {8'b11000000, 16'd0};                                      w_len = 6'd8;  end
            3'd5: begin w_frame = {8'b11000001, rn16};                                       w_len = 6'd24; end
            default: begin w_frame = 24'd0; w_len = 6'd0; end
        endcase
    end

    assign w_crc5_fb  = r_crc5[4]   ^ r_shift[23];
    assign w_crc16_fb = r_crc16[15] ^ r_shift[23];

    always_comb begin
        w_state     = r_state;
        w_shift     = r_shift;
        w_cnt       = r_cnt;
        w_has_crc   = r_has_crc;
        w_crc16_sel = r_crc16_sel;
        w_crc5      = r_crc5;
        w_crc16     = r_crc16;
        case (r_state)
            IDLE: begin
                if (start && (cmd_sel <= 3'd5)) begin
                    w_state     = SEND;
                    w_shift     = w_frame;
                    w_cnt       = w_len;
                    w_has_crc   = (cmd_sel == 3'd2) || (cmd_sel == 3'd5);
                    w_crc16_sel = (cmd_sel == 3'd5);
                    w_crc5      = c_CRC5_PRESET;
                    w_crc16     = c_CRC16_PRESET;
                end
            end
            SEND: begin
                if (bit_req) begin
                    w_shift = {r_shift[22:0], 1'b0};
                    if (r_crc16_sel)
                        w_crc16 = {r_crc16[14:0], 1'b0} ^ (w_crc16_fb ? c_CRC16_POLY : 16'd0);
                    else if (r_has_crc)
                        w_crc5 = {r_crc5[3:0], 1'b0} ^ (w_crc5_fb ? c_CRC5_POLY : 5'd0);
                    if (r_cnt > 6'd1) begin
                        w_cnt = r_cnt - 6'd1;
                    end else if (r_has_crc) begin
                        w_state = CRC;
                        w_cnt   = r_crc16_sel ? 6'd16 : 6'd5;
                    end else begin
                        w_state = DONE;
                        w_cnt   = 6'd0;
                    end
                end
            end
            CRC: begin
                if (bit_req) begin
                    if (r_crc16_sel)
                        w_crc16 = {r_crc16[14:0], 1'b0};
                    else
                        w_crc5 = {r_crc5[3:0], 1'b0};
                    if (r_cnt > 6'd1) begin
                        w_cnt = r_cnt - 6'd1;
                    end else begin
                        w_state = DONE;
                        w_cnt   = 6'd0;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    // Output bit is precomputed from the next state so bitout is a clean flop.
    always_comb begin
        w_bit = 1'b0;
        case (w_state)
            SEND:    w_bit = w_shift[23];
            CRC:     w_bit = w_crc16_sel ? ~w_crc16[15] : w_crc5[4];
            default: w_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_shift     <= 24'd0;
            r_cnt       <= 6'd0;
            r_has_crc   <= 1'b0;
            r_crc16_sel <= 1'b0;
            r_crc5      <= 5'd0;
            r_crc16     <= 16'd0;
            bitout      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_shift     <= w_shift;
            r_cnt       <= w_cnt;
            r_has_crc   <= w_has_crc;
            r_crc16_sel <= w_crc16_sel;
            r_crc5      <= w_crc5;
            r_crc16     <= w_crc16;
            bitout      <= w_bit;
            busy        <= (w_state == SEND) || (w_state == CRC);
            done        <= (w_state == DONE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmd_serializer
//  Purpose  : Directed table-driven bench for cmd_serializer frames and CRCs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  cmd_sel;
    logic        dr, trext, target;
    logic [1:0]  m, sel, session;
    logic [3:0]  q;
    logic [2:0]  updn;
    logic [15:0] rn16;
    logic        bit_req;
    logic        bitout, busy, done;

    int checks = 0;
    int errors = 0;

    cmd_serializer dut (
        .clk(clk), .reset(reset), .start(start), .cmd_sel(cmd_sel),
        .dr(dr), .trext(trext), .target(target), .m(m), .sel(sel),
        .session(session), .q(q), .updn(updn), .rn16(rn16),
        .bit_req(bit_req), .bitout(bitout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cs;
        logic        dr, trext, target;
        logic [1:0]  m, sl, ss;
        logic [3:0]  q;
        logic [2:0]  ud;
        logic [15:0] rn;
        int          plen;
        int          clen;
        logic [23:0] pay;
        logic [15:0] res;
        int          gap;
        int          inj;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] crc5_res(input logic [39:0] b, input int n);
        logic [4:0] c = 5'b01001;
        logic fb;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[4] ^ b[i];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'b01001 : 5'b00000);
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_res(input logic [39:0] b, input int n);
        logic [15:0] c = 16'hFFFF;
        logic fb;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[15] ^ b[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        logic [39:0] cap = 40'd0;
        int n = 0;
        int cyc = 0;
        logic held;
        logic hold_bad = 1'b0;
        logic early_done = 1'b0;
        @(negedge clk);
        cmd_sel = v.cs; dr = v.dr; trext = v.trext; target = v.target;
        m = v.m; sel = v.sl; session = v.ss; q = v.q; updn = v.ud; rn16 = v.rn;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("v%0d_busy_after_start", idx), {39'd0, busy}, 40'd1);
        chk($sformatf("v%0d_first_bit", idx), {39'd0, bitout}, {39'd0, v.pay[23]});
        while (busy && cyc < 400) begin
            held = bitout;
            for (int g = 0; g < v.gap; g++) begin
                @(negedge clk);
                cyc++;
                if (bitout !== held || busy !== 1'b1) hold_bad = 1'b1;
            end
            cap = {cap[38:0], bitout};
            if (n == v.inj) begin
                start = 1'b1; cmd_sel = 3'd4;
                session = ~session; updn = ~updn; rn16 = ~rn16; q = ~q;
            end
            bit_req = 1'b1;
            @(negedge clk);
            bit_req = 1'b0;
            start = 1'b0;
            n++;
            cyc++;
            if (busy && done) early_done = 1'b1;
        end
        chk($sformatf("v%0d_timeout", idx), {39'd0, (cyc >= 400)}, 40'd0);
        chk($sformatf("v%0d_done_pulse", idx), {39'd0, done}, 40'd1);
        chk($sformatf("v%0d_bitout_idle", idx), {39'd0, bitout}, 40'd0);
        chk($sformatf("v%0d_bit_count", idx), 40'(n), 40'(v.plen + v.clen));
        chk($sformatf("v%0d_payload", idx), cap >> v.clen, {16'd0, v.pay} >> (24 - v.plen));
        chk($sformatf("v%0d_early_done", idx), {39'd0, early_done}, 40'd0);
        if (v.clen == 5)
            chk($sformatf("v%0d_crc5_residue", idx), {35'd0, crc5_res(cap, n)}, {24'd0, v.res});
        if (v.clen == 16)
            chk($sformatf("v%0d_crc16_residue", idx), {24'd0, crc16_res(cap, n)}, {24'd0, v.res});
        if (v.gap > 0)
            chk($sformatf("v%0d_hold_between_strobes", idx), {39'd0, hold_bad}, 40'd0);
        @(negedge clk);
        chk($sformatf("v%0d_done_one_cycle", idx), {38'd0, done, busy}, 40'd0);
    endtask

    initial begin
        //          cs    dr    trx   tgt   m      sl     ss     q      ud      rn        pl  cl  payload     res      gap inj
        vecs[0] = '{3'd4, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 16'h0000,  8,  0, 24'hC00000, 16'h0000, 0, -1};
        vecs[1] = '{3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 4'h0, 3'b000, 16'h0000,  4,  0, 24'h200000, 16'h0000, 2, -1};
        vecs[2] = '{3'd2, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 2'b01, 4'h4, 3'b000, 16'h0000, 17,  5, 24'h8D1200, 16'h0000, 0, -1};
        vecs[3] = '{3'd5, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 16'hA5C3, 24, 16, 24'hC1A5C3, 16'h1D0F, 1, -1};
        vecs[4] = '{3'd1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 16'h1234, 18,  0, 24'h448D00, 16'h0000, 0, -1};
        vecs[5] = '{3'd3, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 4'h0, 3'b110, 16'h0000,  9,  0, 24'h9F0000, 16'h0000, 0,  3};
        vecs[6] = '{3'd2, 1'b0, 1'b0, 1'b1, 2'b01, 2'b11, 2'b10, 4'hF, 3'b000, 16'h0000, 17,  5, 24'h82EF80, 16'h0000, 0, -1};
        vecs[7] = '{3'd5, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 16'h0000, 24, 16, 24'hC10000, 16'h1D0F, 0, -1};

        reset = 1'b1; start = 1'b0; cmd_sel = 3'd0; bit_req = 1'b0;
        dr = 1'b0; trext = 1'b0; target = 1'b0; m = 2'b0; sel = 2'b0;
        session = 2'b0; q = 4'h0; updn = 3'b0; rn16 = 16'h0;
        repeat (3) @(negedge clk);
        chk("reset_state", {37'd0, busy, done, bitout}, 40'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {37'd0, busy, done, bitout}, 40'd0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reserved selectors while idle must not start anything.
        for (int k = 6; k < 8; k++) begin
            @(negedge clk);
            cmd_sel = 3'(k);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("reserved_%0d_no_busy", k), {38'd0, busy, done}, 40'd0);
            @(negedge clk);
            chk($sformatf("reserved_%0d_no_done", k), {38'd0, busy, done}, 40'd0);
        end

        // Asynchronous reset in the middle of an Ack frame.
        @(negedge clk);
        cmd_sel = 3'd1; rn16 = 16'hBEEF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) begin
            bit_req = 1'b1;
            @(negedge clk);
            bit_req = 1'b0;
        end
        chk("ack_busy_before_reset", {39'd0, busy}, 40'd1);
        #2 reset = 1'b1;
        #1 chk("ack_async_abort", {37'd0, busy, done, bitout}, 40'd0);
        @(negedge clk);
        reset = 1'b0;
        begin
            logic saw_done = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (done || busy) saw_done = 1'b1;
            end
            chk("ack_abort_no_done", {39'd0, saw_done}, 40'd0);
        end
        run_vec(100, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
